data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store path: a single-port word memory with
//  a valid/ready request channel and a valid/ready response channel. Each transaction
//  has a fixed, parameterised latency. It replaces the zero-latency combinational data

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Fixed-latency single-port word memory that sits behind a valid/ready request
// channel and a valid/ready response channel. Only one transaction is in flight
// at a time. Misaligned or out-of-range accesses are answered with resp_err and
// never touch the array.

module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Counter wide enough for WAIT_CYCLES; at least one bit so the zero-wait
  // configuration still elaborates.
  localparam int CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  // Word index width; at least one bit for a degenerate single-word memory.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth as a 32-bit value so the range check covers every address bit.
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic            lat_write;

  logic            accept;
  logic            commit;
  logic [31:0]     c_addr;
  logic [31:0]     c_wdata;
  logic            c_write;
  logic [31:0]     c_word;
  logic            c_err;
  logic [AW-1:0]   c_idx;
  logic            mem_we;

  logic [31:0]     mem [DEPTH];

  // The handshake outputs are pure functions of the state; req_ready is also
  // forced low while reset is asserted, because the state already sits in IDLE.
  assign req_ready  = (state == IDLE) && rst_n;
  assign resp_valid = (state == RESP);

  // Next-state logic: accept in IDLE, count down in BUSY, wait for the
  // requester in RESP. commit marks the edge that enters RESP.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // With zero wait cycles the commit happens on the accept edge itself, so the
  // live request is used; otherwise the latched copy from the accept edge is.
  always_comb begin
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    c_write = lat_write;
    if (state == IDLE) begin
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_write = req_write;
    end
  end

  // Alignment and range decode on the full address, so high bits never alias
  // back into the array.
  always_comb begin
    c_word = {2'b00, c_addr[31:2]};
    c_err  = (c_addr[1:0] != 2'b00) || (c_word >= DEPTH_W);
    c_idx  = c_word[AW-1:0];
    mem_we = commit && c_write && !c_err && rst_n;
  end

  // State register plus the counter and the request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= CW'(WAIT_CYCLES);
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_write <= req_write;
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Response registers load only on the commit edge and hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err <= c_err;
      if (c_err || c_write) begin
        resp_rdata <= '0;
      end else begin
        resp_rdata <= mem[c_idx];
      end
    end
  end

  // Storage array has no reset; a store only lands on its commit edge, so a
  // reset during BUSY drops it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Scoreboard bench: the driver pushes the expected response of each accepted
// request, the monitor pops and compares whenever a response handshake occurs.
// A second, zero-wait instance is exercised directly for throughput.

module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic hold_low = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [int unsigned];
  int unsigned pool[$];

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Randomly throttle the response channel unless a test is holding it low.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected response from the access rules: word memory, aligned and in range.
  task automatic modelAccess(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output exp_t e);
    longint unsigned a;
    int unsigned     widx;
    a      = longint'(addr);
    widx   = addr / 4;
    e.err  = ((a % 4) != 0) || ((a / 4) >= DEPTH);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (wr) model_mem[widx] = wdata;
      else if (model_mem.exists(widx)) e.rdata = model_mem[widx];
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: req_ready stuck at 0 for addr 0x%08h", addr);
      req_valid = 1'b0;
      return;
    end
    modelAccess(wr, addr, wdata, e);
    e.accept = cycle + 1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic checkOutput(input int first_cycle);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_response: rdata 0x%08h err %0b with nothing outstanding",
               resp_rdata, resp_err);
      return;
    end
    checks--;
    e = sb.pop_front();
    checkValue("resp_rdata", resp_rdata, e.rdata);
    checkValue("resp_err", 32'(resp_err), 32'(e.err));
    checkValue("latency", 32'(first_cycle - e.accept), 32'(W));
  endtask

  // Monitor: tracks a response from first valid to handshake, insists it stays
  // stable while waiting, and scores it on the handshake.
  logic        seen = 1'b0;
  int          first_cycle;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (resp_valid) begin
      if (!seen) begin
        seen        = 1'b1;
        first_cycle = cycle;
        held_rdata  = resp_rdata;
        held_err    = resp_err;
      end else begin
        checkValue("hold_rdata", resp_rdata, held_rdata);
        checkValue("hold_err", 32'(resp_err), 32'(held_err));
      end
      checkValue("req_ready_in_resp", 32'(req_ready), 32'h0);
      if (resp_ready) begin
        checkOutput(first_cycle);
        seen = 1'b0;
      end
    end else if (seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL valid_dropped: resp_valid fell before handshake");
      seen = 1'b0;
    end
  end

  task automatic drainScoreboard();
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkValue("drain_outstanding", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int n;
    int unsigned widx;
    logic [31:0] a;
    rst_n       = 1'b0;
    req_valid   = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0;
    req_valid0  = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    resp_ready0 = 1'b1;

    // Reset state
    #3;
    checkValue("rst_req_ready", 32'(req_ready), 32'h0);
    checkValue("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkValue("rst_resp_rdata", resp_rdata, 32'h0);
    checkValue("rst_resp_err", 32'(resp_err), 32'h0);
    checkValue("rst_w0_req_ready", 32'(req_ready0), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait instance: store then loads, one accept every two cycles
    @(negedge clk);
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h40; req_wdata0 = 32'hCAFE0001;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checkValue("w0_req_ready", 32'(req_ready0), 32'(i % 2 == 0));
      checkValue("w0_resp_valid", 32'(resp_valid0), 32'(i % 2 == 1));
      if (i == 1) begin
        checkValue("w0_store_rdata", resp_rdata0, 32'h0);
        checkValue("w0_store_err", 32'(resp_err0), 32'h0);
        req_write0 = 1'b0;
      end
      if (i >= 3 && i % 2 == 1) begin
        checkValue("w0_load_rdata", resp_rdata0, 32'hCAFE0001);
        checkValue("w0_load_err", 32'(resp_err0), 32'h0);
      end
    end
    req_valid0 = 1'b0;

    // Store/load round trip, misaligned store, range boundaries
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 32'h13, 32'h11111111);
    applyStimulus(1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 32'h1000, 32'h0);
    applyStimulus(1'b1, 32'hFFC, 32'h0BADF00D);
    applyStimulus(1'b0, 32'hFFC, 32'h0);
    applyStimulus(1'b0, 32'h8000_0010, 32'h0);
    drainScoreboard();

    // Stalled response: must hold steady and ignore a request pulse
    hold_low = 1'b1;
    applyStimulus(1'b0, 32'h10, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkValue("stall_resp_valid", 32'(resp_valid), 32'h1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h99999999;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkValue("stall_still_valid", 32'(resp_valid), 32'h1);
    hold_low = 1'b0;
    drainScoreboard();
    applyStimulus(1'b0, 32'h10, 32'h0);
    drainScoreboard();

    // Reset in BUSY discards a pending store
    applyStimulus(1'b1, 32'h20, 32'hAAAA5555);
    applyStimulus(1'b0, 32'h10, 32'h0);
    drainScoreboard();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    checkValue("busy_rst_resp_valid", 32'(resp_valid), 32'h0);
    checkValue("busy_rst_req_ready", 32'(req_ready), 32'h0);
    checkValue("busy_rst_rdata", resp_rdata, 32'h0);
    checkValue("busy_rst_err", 32'(resp_err), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0);
    drainScoreboard();

    // Randomized traffic against the reference model
    pool.push_back(32'h10 / 4);
    pool.push_back(32'h20 / 4);
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          widx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(1008, 1023);
          pool.push_back(widx);
          applyStimulus(1'b1, widx * 4, $urandom);
        end
        4, 5, 6, 7: begin
          widx = pool[$urandom_range(0, pool.size() - 1)];
          applyStimulus(1'b0, widx * 4, $urandom);
        end
        8: begin
          a = ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
          applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
        end
        default: begin
          a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
          applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
        end
      endcase
    end
    drainScoreboard();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
